// File: rtl/nios_uart_pio_stretch.sv
// Purpose : pulse stretcher behind the 1-bit PIO, with an Avalon-MM register window.
// Latency : pio_in sampled high at edge 1 -> stretch_out high after edge SYNC_STAGES+1.
// Backpressure: none; zero-wait slave, reads and writes complete in the cycle presented.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pio_in                asynchronous level from the PIO out_port
//   address/chipselect/   Avalon-MM slave: write = chipselect & ~write_n,
//   write_n/writedata/    readdata is combinational from address (no side effects)
//   readdata
//   stretch_out           high while the stretcher is in HOLD or TRACK
//   irq                   end-of-pulse interrupt, present only when the
//                         PIO_STRETCH_IRQ_EN macro is defined
// Register map: 0 width (RW, 0 stores 1), 1 edge count (RW, write clears),
//               2 status {irq_pend, state[1:0], sync_last}, 3 reads zero.
module nios_uart_pio_stretch #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 50000,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pio_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stretch_out
`ifdef PIO_STRETCH_IRQ_EN
  ,output logic        irq
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_HOLD  = 2'b01;
   localparam logic [1:0] ST_TRACK = 2'b10;

   localparam logic [CNT_W-1:0] WIDTH_RST = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;
   logic                   prev_q;
   logic                   rise;
   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [CNT_W-1:0]       width_q;
   logic [CNT_W-1:0]       edge_cnt_q;
   logic                   wr_en;
   logic                   wr_width;
   logic                   wr_edge;
   logic                   irq_pend_q;
   logic                   unused_wdata;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign rise      = sync_last & ~prev_q;

   assign wr_en    = chipselect & ~write_n;
   assign wr_width = wr_en & (address == 2'd0);
   assign wr_edge  = wr_en & (address == 2'd1);

   // Upper writedata bits are simply not stored anywhere.
   assign unused_wdata = ^writedata;

   // Next-state logic. A rise always wins: it reloads the full width even
   // from HOLD, which is how back-to-back pulses merge into one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HOLD;
               cnt_d   = width_q - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (rise) begin
               cnt_d = width_q - CNT_ONE;
            end else if (cnt_q == '0) begin
               // Minimum width served; keep following the input if still high.
               state_d = sync_last ? ST_TRACK : ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_TRACK: begin
            if (rise) begin
               state_d = ST_HOLD;
               cnt_d   = width_q - CNT_ONE;
            end else if (!sync_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pio_in};
         prev_q  <= sync_last;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Width only feeds the reload path, so a new value never disturbs a
   // pulse already in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         width_q <= WIDTH_RST;
      end else if (wr_width) begin
         width_q <= (writedata[CNT_W-1:0] == '0) ? CNT_ONE : writedata[CNT_W-1:0];
      end
   end

   // A clear that coincides with a rise keeps that rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cnt_q <= '0;
      end else if (wr_edge) begin
         edge_cnt_q <= rise ? CNT_ONE : '0;
      end else if (rise && (edge_cnt_q != CNT_MAX)) begin
         edge_cnt_q <= edge_cnt_q + CNT_ONE;
      end
   end

`ifdef PIO_STRETCH_IRQ_EN
   logic wr_status;
   logic pulse_end;

   assign wr_status = wr_en & (address == 2'd2);
   assign pulse_end = (state_q != ST_IDLE) & (state_d == ST_IDLE);

   // Set has priority so an end-of-pulse racing a clear is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_pend_q <= 1'b0;
      end else if (pulse_end) begin
         irq_pend_q <= 1'b1;
      end else if (wr_status && writedata[3]) begin
         irq_pend_q <= 1'b0;
      end
   end

   assign irq = irq_pend_q;
`else
   assign irq_pend_q = 1'b0;
`endif

   assign stretch_out = (state_q != ST_IDLE);

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[CNT_W-1:0] = width_q;
         2'd1:    readdata[CNT_W-1:0] = edge_cnt_q;
         2'd2:    readdata[3:0]       = {irq_pend_q, state_q, sync_last};
         default: readdata            = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_uart_pio_stretch.sv
// Bench for nios_uart_pio_stretch. Stimulus pushes expected pulses and
// read values into queues; a negedge monitor pops and compares them.
// A second instance with a 4-bit counter exercises edge-count saturation.
module tb_nios_uart_pio_stretch;

   localparam int S    = 2;
   localparam int MINW = 50000;
   localparam int CW   = 16;
   localparam int SATW = 4;
   localparam int SAT_MAX = 15;
   localparam int CNT_MAX = 65535;
`ifdef PIO_STRETCH_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, pio_in, chipselect, write_n, stretch_out;
   logic [1:0]  address;
   logic [31:0] writedata, readdata;
   logic        sat_reset, sat_cs, sat_write_n, sat_stretch;
   logic [1:0]  sat_address;
   logic [31:0] sat_writedata, sat_readdata;
`ifdef PIO_STRETCH_IRQ_EN
   logic        irq, sat_irq;
`endif

   always #5 clk = ~clk;

   nios_uart_pio_stretch #(.SYNC_STAGES(S), .MIN_WIDTH(MINW), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset), .pio_in(pio_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .stretch_out(stretch_out)
`ifdef PIO_STRETCH_IRQ_EN
     ,.irq(irq)
`endif
   );

   nios_uart_pio_stretch #(.SYNC_STAGES(S), .MIN_WIDTH(3), .CNT_W(SATW)) u_sat (
      .clk(clk), .reset(sat_reset), .pio_in(pio_in), .address(sat_address),
      .chipselect(sat_cs), .write_n(sat_write_n), .writedata(sat_writedata),
      .readdata(sat_readdata), .stretch_out(sat_stretch)
`ifdef PIO_STRETCH_IRQ_EN
     ,.irq(sat_irq)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {int s; int e;} pulse_t;
   typedef struct {int addr; logic [31:0] data;} rd_t;
   pulse_t      exp_q[$];
   rd_t         rd_q[$];
   logic [31:0] sat_q[$];
   bit          pat_q[$];

   // reference model state
   int width_exp, edge_exp, total_rises;
   bit irq_exp, irq_pending_set;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] st(bit ip, logic [1:0] s, bit sl);
      return {28'd0, ip, s, sl};
   endfunction

   // ---------------- monitor ----------------
   bit     mon_hi = 1'b0;
   int     mon_s  = 0;
   pulse_t mon_p;
   rd_t    mon_r;

   always @(negedge clk) begin
      if (stretch_out === 1'b1 && !mon_hi) begin
         mon_hi = 1'b1;
         mon_s  = cyc;
      end else if (stretch_out !== 1'b1 && mon_hi) begin
         mon_hi = 1'b0;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pulse_unexpected: got pulse %0d..%0d, expected none", mon_s, cyc - 1);
         end else begin
            mon_p = exp_q.pop_front();
            chk("pulse_start", mon_s, mon_p.s);
            chk("pulse_end", cyc - 1, mon_p.e);
         end
      end
      if (chipselect === 1'b1 && write_n === 1'b1) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected: got read at cycle %0d, expected none", cyc);
         end else begin
            mon_r = rd_q.pop_front();
            chk($sformatf("read_a%0d", mon_r.addr), readdata, mon_r.data);
`ifdef PIO_STRETCH_IRQ_EN
            if (mon_r.addr == 2) chk("irq_pin", {31'd0, irq}, {31'd0, mon_r.data[3]});
`endif
         end
      end
      if (sat_cs === 1'b1) begin
         if (sat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sat_read_unexpected: got read at cycle %0d, expected none", cyc);
         end else begin
            chk("sat_edge_cnt", sat_readdata, sat_q.pop_front());
         end
      end
   end

   // ---------------- bus tasks ----------------
   task automatic rd(int a, logic [31:0] e);
      rd_t r;
      @(posedge clk); #1;
      r.addr = a;
      r.data = e;
      rd_q.push_back(r);
      address    = a[1:0];
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0;
   endtask

   task automatic wr(int a, logic [31:0] d);
      @(posedge clk); #1;
      address    = a[1:0];
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_sat(logic [31:0] e);
      @(posedge clk); #1;
      sat_q.push_back(e);
      sat_address = 2'd1;
      sat_cs      = 1'b1;
      @(posedge clk); #1;
      sat_cs = 1'b0;
   endtask

   task automatic add_run(int gap, int len);
      for (int i = 0; i < gap; i++) pat_q.push_back(1'b0);
      for (int i = 0; i < len; i++) pat_q.push_back(1'b1);
   endtask

   // Each input run sampled from edge k for L cycles gives output high for
   // cycles k+S .. k+S+max(W,L)-1; touching or overlapping intervals merge.
   // clr_idx >= 0 also writes addr1 in the cycle that drives pat_q[clr_idx].
   task automatic drive_pattern(int clr_idx);
      int base, n, j, len, s, e, nr, cnt_after, ps, pe;
      bit pv;
      pulse_t p;
      @(posedge clk); #1;
      base = cyc;
      n = pat_q.size();
      nr = 0; cnt_after = 0; pv = 1'b0; ps = 0; pe = 0;
      j = 0;
      while (j < n) begin
         if (pat_q[j] && (j == 0 || !pat_q[j-1])) begin
            len = 0;
            while (j + len < n && pat_q[j+len]) len++;
            s = base + 1 + j + S;
            e = s + ((width_exp > len) ? width_exp : len) - 1;
            if (pv && s <= pe + 1) begin
               pe = (e > pe) ? e : pe;
            end else begin
               if (pv) begin p.s = ps; p.e = pe; exp_q.push_back(p); end
               ps = s; pe = e; pv = 1'b1;
            end
            nr++;
            if (clr_idx >= 0 && j + S >= clr_idx) cnt_after++;
            j += len;
         end else begin
            j++;
         end
      end
      if (pv) begin p.s = ps; p.e = pe; exp_q.push_back(p); end
      if (clr_idx >= 0) edge_exp = cnt_after;
      else edge_exp = (edge_exp + nr > CNT_MAX) ? CNT_MAX : edge_exp + nr;
      total_rises += nr;
      if (nr > 0) irq_pending_set = 1'b1;
      for (int i = 0; i < n; i++) begin
         pio_in = pat_q[i];
         if (clr_idx >= 0) begin
            if (i == clr_idx) begin
               address    = 2'd1;
               writedata  = $urandom;
               chipselect = 1'b1;
               write_n    = 1'b0;
            end else begin
               chipselect = 1'b0;
               write_n    = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      pio_in     = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      pat_q.delete();
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pulse_timeout: got %0d pulses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      if (irq_pending_set) irq_exp = IRQ_ON;
      irq_pending_set = 1'b0;
   endtask

   function automatic int sat_exp();
      return (total_rises > SAT_MAX) ? SAT_MAX : total_rises;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int w, nruns, base;
      pulse_t p;
      reset = 1'b1; sat_reset = 1'b1; pio_in = 1'b0;
      chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
      sat_cs = 1'b0; sat_write_n = 1'b1; sat_address = 2'd0; sat_writedata = '0;
      width_exp = MINW; edge_exp = 0; total_rises = 0;
      irq_exp = 1'b0; irq_pending_set = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      sat_reset = 1'b0;

      // reset state
      chk("reset_stretch", {31'd0, stretch_out}, 32'd0);
      rd(0, MINW); rd(1, 0); rd(2, 0); rd(3, 0);
      rd_sat(0);

      // register semantics
      wr(0, 32'hFFFF_000A); width_exp = 10; rd(0, 10);
      wr(3, 32'hDEAD_BEEF); rd(3, 0);

      // short pulse; status sampled mid-HOLD
      add_run(0, 1);
      drive_pattern(-1);
      repeat (S) @(posedge clk);
      rd(2, st(irq_exp, 2'b01, 1'b0));
      wait_drain();
      rd(1, edge_exp);
      rd(2, st(irq_exp, 2'b00, 1'b0));

      // long pulse; status sampled in TRACK
      add_run(0, 30);
      drive_pattern(-1);
      rd(2, st(irq_exp, 2'b10, 1'b1));
      wait_drain();
      rd(1, edge_exp);

      // interrupt pending clears on write of bit3 (ignored without the feature)
      rd(2, st(irq_exp, 2'b00, 1'b0));
      wr(2, 32'h8);
      irq_exp = 1'b0;
      rd(2, st(irq_exp, 2'b00, 1'b0));

      // retrigger: second pulse 6 cycles after the first
      add_run(0, 1);
      add_run(5, 1);
      drive_pattern(-1);
      wait_drain();
      rd(1, edge_exp);

      // clear of edge count in the same cycle as a rise
      add_run(0, 1);
      add_run(S + 1, 0);
      drive_pattern(S);
      wait_drain();
      rd(1, edge_exp);
      wr(1, 32'h0); edge_exp = 0; rd(1, 0);
      rd_sat(sat_exp());

      // 20 pulses: small counter saturates
      for (int i = 0; i < 20; i++) add_run(2, 1);
      drive_pattern(-1);
      wait_drain();
      rd(1, edge_exp);
      rd_sat(sat_exp());

      // width 0 stores 1, then random traffic at assorted widths
      wr(0, 32'h0); width_exp = 1; rd(0, 1);
      for (int ph = 0; ph < 8; ph++) begin
         if (ph > 0) begin
            w = $urandom_range(1, 12);
            wr(0, w);
            width_exp = w;
            rd(0, w);
         end
         nruns = $urandom_range(3, 8);
         for (int r = 0; r < nruns; r++) add_run($urandom_range(1, 15), $urandom_range(1, 25));
         drive_pattern(-1);
         wait_drain();
         rd(1, edge_exp);
         rd(2, st(irq_exp, 2'b00, 1'b0));
      end

      // reset asserted mid-HOLD truncates the pulse on the same edge
      wr(0, 10); width_exp = 10;
      @(posedge clk); #1;
      base = cyc;
      pio_in = 1'b1;
      p.s = base + 1 + S;
      p.e = base + S + 3;
      exp_q.push_back(p);
      total_rises++;
      @(posedge clk); #1;
      pio_in = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_mid_stretch", {31'd0, stretch_out}, 32'd0);
`ifdef PIO_STRETCH_IRQ_EN
      chk("reset_mid_irq", {31'd0, irq}, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      width_exp = MINW; edge_exp = 0; irq_exp = 1'b0; irq_pending_set = 1'b0;
      wait_drain();
      rd(0, MINW); rd(1, 0); rd(2, 0); rd(3, 0);
      rd_sat(sat_exp());

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
